lcd_16207_timed_ctrl: RTL and testbench
=======================================

# lcd_16207_timed_ctrl

Avalon-MM slave that drives an HD44780-compatible character LCD (16207 module) with on-chip bus-cycle timing, replacing the purely combinational strobe path in which LCD_E simply followed read|write. A small FSM generates address-setup, enable-pulse and hold phases from parametrised cycle counts, and stalls the bus with waitrequest until the LCD cycle is complete. The block supports 8-bit or 4-bit (nibble) LCD buses and sits between the system interconnect and the LCD pins.

## Interface
Parameters:
- BUS_W, 8, LCD data-bus width; legal values 8 or 4 (4 selects nibble mode on D7..D4).
- T_SETUP, 2, clk cycles RS/RW/data are stable before LCD_E rises; ≥1.
- T_PULSE, 12, clk cycles LCD_E is high; ≥1.
- T_HOLD, 12, clk cycles RS/RW/data are held after LCD_E falls; ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  [0] = LCD RW (1 = read), [1] = LCD RS (1 = data register).
- read  in  1  Avalon read request.
- write  in  1  Avalon write request.
- writedata  in  8  byte to write.
- readdata  out  8  byte read from the LCD; valid in the cycle waitrequest is low.
- waitrequest  out  1  Avalon stall.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  read/not-write.
- LCD_data  inout  BUS_W  LCD data pins, tri-stated when not driving.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, DONE. In 4-bit mode a nibble flag selects the first or second pass.
- IDLE: when read|write is high, latch address and writedata, clear the nibble flag, and go to SETUP.
- SETUP (T_SETUP cycles) → PULSE (T_PULSE cycles, LCD_E=1) → HOLD (T_HOLD cycles).
- HOLD exit, 8-bit mode: go to DONE.
- HOLD exit, 4-bit mode, first pass: set the nibble flag and go to SETUP.
- HOLD exit, 4-bit mode, second pass: go to DONE.
- DONE: lasts one cycle with waitrequest=0, then returns to IDLE. A request still asserted in IDLE starts a new transfer, so back-to-back accesses are allowed.
- Transfer type follows the latched address[0] only. read/write merely trigger a transfer; read and write asserted together give one transfer.
- LCD_RS and LCD_RW come from the latched address. They change only on IDLE→SETUP and keep their value while idle.
- LCD_data is driven only when latched RW=0, from SETUP through HOLD; it is Z otherwise.
  - 8-bit mode: drives writedata.
  - 4-bit mode: drives writedata[7:4] on the first pass and [3:0] on the second.
- Read capture happens on the last PULSE cycle.
  - 8-bit mode: LCD_data → readdata.
  - 4-bit mode: first pass → readdata[7:4], second pass → readdata[3:0].
  - readdata holds its value until the next read capture.
- A single down-counter is loaded on each phase entry with (T_x − 1) and the phase advances when the counter reaches 0. Width is $clog2(max(T_SETUP, T_PULSE, T_HOLD)).

## Timing
- Reset values: state IDLE, LCD_E 0, LCD_RS 0, LCD_RW 0, LCD_data Z, readdata 0, waitrequest 1.
- waitrequest = (state != DONE). It is high in IDLE, so a new request always stalls at least one cycle.
- Request-to-completion time (waitrequest low), counting the request cycle as cycle 0:
  - 8-bit mode: 1+T_SETUP+T_PULSE+T_HOLD cycles.
  - 4-bit mode: 1+2·(T_SETUP+T_PULSE+T_HOLD) cycles.
- With defaults at 50 MHz one LCD cycle is 520 ns: tAS 40 ns, PW_EH 240 ns, tH 240 ns, meeting HD44780 limits.
- LCD_E, LCD_RS, LCD_RW and the data output enable are registered, so there are no glitches.
- Reset asserted mid-transfer: all outputs go to reset values immediately. LCD_E drops asynchronously and the transfer is discarded.
- Request deasserted mid-transfer (protocol violation): the transfer still completes and DONE is still produced.

## Structure
- Package lcd_16207_pkg holds:
  - the state enum;
  - the RW/RS bit-index constants;
  - a function returning the counter width from the three timing parameters.
- Sub-module lcd_phase_timer: loadable down-counter with inputs load and load_value, and output zero.
- The top level contains the FSM, address/data latches, nibble flag, tri-state buffer and Avalon logic.
- An elaboration-time check fails if BUS_W ∉ {4,8} or any T_x < 1.

## Test plan
- Reset then idle: after reset, LCD_E=0, LCD_data=Z, waitrequest=1, readdata=0.
- 8-bit write, defaults, address=2'b00, writedata=0x38:
  - LCD_RS=0, LCD_RW=0, LCD_data=0x38 from cycle 1 to cycle 26;
  - LCD_E high exactly in cycles 3–14;
  - waitrequest low only in cycle 27.
- 8-bit read, address=2'b01, LCD model drives 0x80 (busy flag) while LCD_E=1:
  - readdata=0x80 when waitrequest is low;
  - LCD_data is never driven by the DUT.
- 4-bit write, BUS_W=4, T_SETUP=T_PULSE=T_HOLD=1, address=2'b10, writedata=0xA5:
  - two LCD_E pulses with data 0xA then 0x5;
  - waitrequest low at cycle 7.
- Back-to-back: write held high for two transfers gives two complete LCD cycles separated by DONE→IDLE, with no LCD_E overlap.
- Reset asserted in PULSE: LCD_E falls in the same cycle; after release, a new write completes normally with correct timing.

Source files
------------

// File: rtl/lcd_16207_pkg.sv
// Shared types and helpers for the timed 16207 character-LCD controller.
package lcd_16207_pkg;

  // Bus-cycle phases of one LCD access.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } lcd_state_t;

  // Bit positions inside the Avalon address word.
  localparam int RW_BIT = 0;
  localparam int RS_BIT = 1;

  // Phase counter width: enough to hold the largest (T_x - 1), never below 1 bit.
  function automatic int timer_width(input int t_setup, input int t_pulse, input int t_hold);
    int longest;
    longest = t_setup;
    if (t_pulse > longest) longest = t_pulse;
    if (t_hold > longest) longest = t_hold;
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times each LCD bus phase; zero flags the last cycle.
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_16207_timed_ctrl.sv
// Avalon-MM slave driving an HD44780-style LCD with timed setup/enable/hold phases.
// In 4-bit mode every access is split into two passes, high nibble first.
module lcd_16207_timed_ctrl
  import lcd_16207_pkg::*;
#(
  parameter int BUS_W   = 8,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [7:0]       writedata,
  output logic [7:0]       readdata,
  output logic             waitrequest,
  output logic             LCD_E,
  output logic             LCD_RS,
  output logic             LCD_RW,
  inout  wire  [BUS_W-1:0] LCD_data
);

  localparam int CW = timer_width(T_SETUP, T_PULSE, T_HOLD);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);

  generate
    if (!(BUS_W == 4 || BUS_W == 8) || T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1) begin : g_param_check
      $error("lcd_16207_timed_ctrl: BUS_W must be 4 or 8 and every T_x at least 1");
    end
  endgenerate

  lcd_state_t       state;
  logic [7:0]       wdata_q;
  logic             nibble;
  logic             drive_en;
  logic             timer_load;
  logic [CW-1:0]    timer_value;
  logic             timer_zero;
  logic [BUS_W-1:0] data_out;
  logic [7:0]       rd_next;

  lcd_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // Nibble steering for outgoing data and for assembling the captured read byte.
  generate
    if (BUS_W == 8) begin : g_bus8
      assign data_out = wdata_q;
      assign rd_next  = LCD_data;
    end else begin : g_bus4
      assign data_out = nibble ? wdata_q[3:0] : wdata_q[7:4];
      assign rd_next  = nibble ? {readdata[7:4], LCD_data} : {LCD_data, readdata[3:0]};
    end
  endgenerate

  assign LCD_data    = drive_en ? data_out : {BUS_W{1'bz}};
  assign waitrequest = (state != ST_DONE);

  // Reload the phase timer whenever the FSM enters a timed phase.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = LD_SETUP;
    case (state)
      ST_IDLE:  if (read || write) timer_load = 1'b1;
      ST_SETUP: if (timer_zero) begin timer_load = 1'b1; timer_value = LD_PULSE; end
      ST_PULSE: if (timer_zero) begin timer_load = 1'b1; timer_value = LD_HOLD; end
      ST_HOLD:  if (timer_zero && BUS_W == 4 && !nibble) timer_load = 1'b1;
      default:  ;
    endcase
  end

  // Bus-cycle FSM; all LCD-side controls are registered so the pins never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b0;
      drive_en <= 1'b0;
      nibble   <= 1'b0;
      wdata_q  <= '0;
      readdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (read || write) begin
            wdata_q  <= writedata;
            nibble   <= 1'b0;
            LCD_RS   <= address[RS_BIT];
            LCD_RW   <= address[RW_BIT];
            drive_en <= ~address[RW_BIT];
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (timer_zero) begin
            LCD_E <= 1'b1;
            state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (timer_zero) begin
            LCD_E <= 1'b0;
            if (LCD_RW) readdata <= rd_next;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (timer_zero) begin
            if (BUS_W == 4 && !nibble) begin
              nibble <= 1'b1;
              state  <= ST_SETUP;
            end else begin
              drive_en <= 1'b0;
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_16207_timed_ctrl.sv
// Directed bench: one default 8-bit controller and one 4-bit controller with unit timing.
// Undriven LCD pins are pulled up, so a tri-stated 8-bit bus reads 0xFF and a 4-bit bus 0xF.
module tb_lcd_16207_timed_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit instance, default timing
  logic [1:0] addr8;
  logic       rd8, wr8;
  logic [7:0] wd8, rdata8;
  logic       wait8, e8, rs8, rw8;
  wire  [7:0] d8;

  // 4-bit instance, T_SETUP = T_PULSE = T_HOLD = 1
  logic [1:0] addr4;
  logic       rd4, wr4;
  logic [7:0] wd4, rdata4;
  logic       wait4, e4, rs4, rw4;
  wire  [3:0] d4;
  logic [3:0] nib4;

  lcd_16207_timed_ctrl dut8 (
    .clk(clk), .reset(reset), .address(addr8), .read(rd8), .write(wr8),
    .writedata(wd8), .readdata(rdata8), .waitrequest(wait8),
    .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_data(d8)
  );

  lcd_16207_timed_ctrl #(.BUS_W(4), .T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut4 (
    .clk(clk), .reset(reset), .address(addr4), .read(rd4), .write(wr4),
    .writedata(wd4), .readdata(rdata4), .waitrequest(wait4),
    .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_data(d4)
  );

  // LCD models: answer reads only while the enable strobe is high.
  assign d8 = (e8 && rw8) ? 8'h80 : 8'hzz;
  assign d4 = (e4 && rw4) ? nib4 : 4'hz;

  for (genvar i = 0; i < 8; i++) begin : g_pu8
    pullup (d8[i]);
  end
  for (genvar i = 0; i < 4; i++) begin : g_pu4
    pullup (d4[i]);
  end

  task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One 8-bit access with default timing; called at a negedge, which is cycle 0.
  task automatic run8(input logic [1:0] a, input logic [7:0] wd, input logic [7:0] rd_exp);
    addr8 = a;
    wd8   = wd;
    if (a[0]) rd8 = 1'b1; else wr8 = 1'b1;
    chk("r8_wait_c0", 0, 8'(wait8), 8'h01);
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      chk("x8_e", n, 8'(e8), 8'((n >= 3 && n <= 14) ? 1 : 0));
      chk("x8_wait", n, 8'(wait8), 8'((n != 27) ? 1 : 0));
      chk("x8_rs", n, 8'(rs8), 8'(a[1]));
      chk("x8_rw", n, 8'(rw8), 8'(a[0]));
      if (a[0])
        chk("r8_bus", n, d8, (n >= 3 && n <= 14) ? 8'h80 : 8'hFF);
      else
        chk("w8_bus", n, d8, (n >= 1 && n <= 26) ? wd : 8'hFF);
      if (n == 27) begin
        if (a[0]) chk("r8_readdata", n, rdata8, rd_exp);
        rd8 = 1'b0;
        wr8 = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    addr8 = 2'b00; rd8 = 1'b0; wr8 = 1'b0; wd8 = 8'h00;
    addr4 = 2'b00; rd4 = 1'b0; wr4 = 1'b0; wd4 = 8'h00; nib4 = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_e8", 0, 8'(e8), 8'h00);
    chk("rst_wait8", 0, 8'(wait8), 8'h01);
    chk("rst_rdata8", 0, rdata8, 8'h00);
    chk("rst_bus8", 0, d8, 8'hFF);
    chk("rst_rs8", 0, 8'(rs8), 8'h00);
    chk("rst_rw8", 0, 8'(rw8), 8'h00);
    chk("rst_e4", 0, 8'(e4), 8'h00);
    chk("rst_bus4", 0, 8'(d4), 8'h0F);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_wait8", 0, 8'(wait8), 8'h01);
    chk("idle_e8", 0, 8'(e8), 8'h00);
    chk("idle_bus8", 0, d8, 8'hFF);

    // 8-bit instruction write, then busy-flag read
    run8(2'b00, 8'h38, 8'h00);
    run8(2'b01, 8'h00, 8'h80);

    // 4-bit write of 0xA5 to the data register
    addr4 = 2'b10; wd4 = 8'hA5; wr4 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      chk("w4_e", n, 8'(e4), 8'((n == 2 || n == 5) ? 1 : 0));
      chk("w4_wait", n, 8'(wait4), 8'((n != 7) ? 1 : 0));
      chk("w4_bus", n, 8'(d4), (n <= 3) ? 8'h0A : ((n <= 6) ? 8'h05 : 8'h0F));
      chk("w4_rs", n, 8'(rs4), 8'h01);
      chk("w4_rw", n, 8'(rw4), 8'h00);
      if (n == 7) wr4 = 1'b0;
    end

    // 4-bit read: LCD returns 0xC then 0x3
    addr4 = 2'b01; wd4 = 8'h00; rd4 = 1'b1; nib4 = 4'hC;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      chk("r4_e", n, 8'(e4), 8'((n == 2 || n == 5) ? 1 : 0));
      chk("r4_bus", n, 8'(d4), (n == 2) ? 8'h0C : ((n == 5) ? 8'h03 : 8'h0F));
      if (n == 3) nib4 = 4'h3;
      if (n == 7) begin
        chk("r4_wait", n, 8'(wait4), 8'h00);
        chk("r4_readdata", n, rdata4, 8'hC3);
        rd4 = 1'b0;
      end
    end

    // Back-to-back 8-bit writes with write held high
    addr8 = 2'b10; wd8 = 8'h38; wr8 = 1'b1;
    for (int n = 1; n <= 56; n++) begin
      @(negedge clk);
      chk("b2b_e", n, 8'(e8), 8'(((n >= 3 && n <= 14) || (n >= 31 && n <= 42)) ? 1 : 0));
      chk("b2b_wait", n, 8'(wait8), 8'((n != 27 && n != 55) ? 1 : 0));
      chk("b2b_bus", n, d8, (n >= 1 && n <= 26) ? 8'h38 : ((n >= 29 && n <= 54) ? 8'h41 : 8'hFF));
      chk("b2b_rs", n, 8'(rs8), 8'h01);
      if (n == 27) wd8 = 8'h41;
      if (n == 55) wr8 = 1'b0;
    end

    // Reset during the enable pulse, then a clean write
    addr8 = 2'b00; wd8 = 8'h55; wr8 = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_e_before", 5, 8'(e8), 8'h01);
    #2 reset = 1'b1;
    #1;
    chk("mid_e_after", 5, 8'(e8), 8'h00);
    chk("mid_wait", 5, 8'(wait8), 8'h01);
    chk("mid_bus", 5, d8, 8'hFF);
    chk("mid_rdata", 5, rdata8, 8'h00);
    chk("mid_rs", 5, 8'(rs8), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    run8(2'b00, 8'h55, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
